// File: rtl/tz_scan_ctrl.sv
// tz_scan_ctrl: sequential trailing-zero counter for a 16-bit word, scanned one
// 4-bit nibble per cycle from the LSB end.
//
// Ports:
//   clk       in   sole clock, rising edge
//   rst_n     in   synchronous active-low reset
//   in_valid  in   in_data holds a word to scan
//   in_ready  out  high only in IDLE
//   in_data   in   [15:0] word to scan
//   out_valid out  high only in DONE
//   out_ready in   consumer takes the result (only looked at in DONE)
//   out_count out  [4:0] trailing-zero count, 0..16
//   out_zero  out  scanned word was 0x0000
//   busy      out  high in SCAN or DONE
//
// Build option: define TZ_SCAN_CTRL_EARLY_EXIT_EN to leave SCAN on the first
// nonzero nibble (1..4 cycle latency). Without it SCAN always takes 4 cycles.
module tz_scan_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_count,
  output logic        out_zero,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] word_q, word_d;
  logic [4:0]  count_q, count_d;
  logic        zero_q, zero_d;

  logic [3:0]  nib;
  logic [2:0]  nib_tz;
  logic [4:0]  nib_cnt;

  // Trailing zeros within one nibble, 4 when the nibble is zero.
  function automatic logic [2:0] calc_tz(input logic [3:0] n);
    if (n[0])      return 3'd0;
    else if (n[1]) return 3'd1;
    else if (n[2]) return 3'd2;
    else if (n[3]) return 3'd3;
    else           return 3'd4;
  endfunction

  assign nib     = word_q[{idx_q, 2'b00} +: 4];
  assign nib_tz  = calc_tz(nib);
  // At idx 3 with a zero nibble this yields 12 + 4 = 16, the all-zero count.
  assign nib_cnt = {1'b0, idx_q, 2'b00} + {2'b00, nib_tz};

`ifndef TZ_SCAN_CTRL_EARLY_EXIT_EN
  // Full-length scan: remember the first nonzero nibble's result until idx 3.
  logic       found_q, found_d;
  logic [4:0] pend_q, pend_d;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    count_d = count_q;
    zero_d  = zero_q;
`ifndef TZ_SCAN_CTRL_EARLY_EXIT_EN
    found_d = found_q;
    pend_d  = pend_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          word_d  = in_data;
          idx_d   = 2'd0;
          state_d = StScan;
`ifndef TZ_SCAN_CTRL_EARLY_EXIT_EN
          found_d = 1'b0;
          pend_d  = 5'd0;
`endif
        end
      end
      StScan: begin
`ifdef TZ_SCAN_CTRL_EARLY_EXIT_EN
        if (nib != 4'd0 || idx_q == 2'd3) begin
          count_d = nib_cnt;
          zero_d  = (nib == 4'd0);
          state_d = StDone;
        end else begin
          idx_d = idx_q + 2'd1;
        end
`else
        if (!found_q && nib != 4'd0) begin
          found_d = 1'b1;
          pend_d  = nib_cnt;
        end
        if (idx_q == 2'd3) begin
          count_d = found_q ? pend_q : nib_cnt;
          zero_d  = !found_q && (nib == 4'd0);
          state_d = StDone;
        end else begin
          idx_d = idx_q + 2'd1;
        end
`endif
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= 2'd0;
      word_q  <= 16'd0;
      count_q <= 5'd0;
      zero_q  <= 1'b0;
`ifndef TZ_SCAN_CTRL_EARLY_EXIT_EN
      found_q <= 1'b0;
      pend_q  <= 5'd0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      count_q <= count_d;
      zero_q  <= zero_d;
`ifndef TZ_SCAN_CTRL_EARLY_EXIT_EN
      found_q <= found_d;
      pend_q  <= pend_d;
`endif
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StScan) || (state_q == StDone);
  assign out_count = count_q;
  assign out_zero  = zero_q;

endmodule

// File: doc/tz_scan_ctrl.md
TZ_SCAN_CTRL -- requirements
Module: tz_scan_ctrl

Interface
REQ-001 No parameters; data width fixed at 16 bits, scanned as four 4-bit nibbles.
REQ-002 One clock; reset is synchronous and active-low.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 in_valid  input  1  in_data holds a word to scan.
REQ-006 in_ready  output  1  block can accept a word.
REQ-007 in_data  input  16  word whose trailing zeros are counted.
REQ-008 out_valid  output  1  out_count/out_zero hold a result.
REQ-009 out_ready  input  1  consumer takes the result.
REQ-010 out_count  output  5  trailing-zero count, 0..16.
REQ-011 out_zero  output  1  high when the scanned word was 0x0000.
REQ-012 busy  output  1  high in SCAN or DONE.

Function
REQ-013 FSM states: IDLE, SCAN, DONE; encoding is free.
REQ-014 in_ready = 1 only in IDLE; busy = 1 in SCAN and DONE; out_valid = 1 only in DONE.
REQ-015 Accept on a rising edge with in_valid && in_ready: capture in_data into an internal 16-bit register, clear the 2-bit nibble index to 0, go to SCAN.
REQ-016 In SCAN, examine one nibble per cycle, nibble[idx] = word[4*idx+3 : 4*idx], from idx 0 (LSBs) upward.
REQ-017 Per-nibble trailing-zero count tz(n): 0 if n[0]=1, 1 if n[1:0]=10b, 2 if n[2:0]=100b, 3 if n=1000b, 4 if n=0000b.
REQ-018 First nonzero nibble at idx k: result count = 4*k + tz(nibble); out_zero = 0.
REQ-019 All four nibbles zero: count = 16, out_zero = 1.
REQ-020 With early exit (REQ-029), SCAN to DONE on the edge that examines the first nonzero nibble, or idx 3; out_valid rises k+1 edges after the accept edge (k = 3 for all-zero).
REQ-021 idx increments on each SCAN edge; it does not wrap, because SCAN always exits at idx 3.
REQ-022 In DONE, out_count and out_zero are stable; with out_ready = 1 on an edge go to IDLE; otherwise stay in DONE indefinitely.
REQ-023 No overlap: a new word is not accepted on the same edge a result is taken; in_ready rises the cycle after the DONE to IDLE transition.
REQ-024 in_data and in_valid are ignored outside IDLE; out_ready is ignored outside DONE.
REQ-025 out_count and out_zero keep the last result through IDLE and SCAN until the next DONE overwrites them.

Reset
REQ-026 rst_n = 0 on an edge forces IDLE, idx = 0, captured word = 0, out_count = 0, out_zero = 0.
REQ-027 Reset outputs: in_ready = 1, out_valid = 0, busy = 0.
REQ-028 Reset in SCAN or DONE discards the operation; no out_valid pulse follows.

Configuration
REQ-029 Macro TZ_SCAN_CTRL_EARLY_EXIT_EN defined: SCAN exits per REQ-020; latency is 1..4 edges.
REQ-030 Macro not defined: SCAN always runs 4 edges (idx 0..3) and latches the result at the first nonzero nibble; out_valid rises exactly 4 edges after accept; result values are identical to REQ-018/019.

Verification
REQ-031 in_data = 0x0001 -> out_count = 0, out_zero = 0; out_valid after 1 edge (EN) or 4 edges (not EN).
REQ-032 in_data = 0x0080 -> out_count = 7, out_zero = 0; out_valid after 2 edges (EN) or 4 edges (not EN).
REQ-033 in_data = 0x8000 -> out_count = 15; in_data = 0x0000 -> out_count = 16, out_zero = 1; both after 4 edges.
REQ-034 Result 0x0040 with out_ready held 0 for 5 cycles -> out_valid = 1, out_count = 6, in_ready = 0 throughout; in_valid pulses are ignored; IDLE follows the first out_ready edge.
REQ-035 Accept 0x1000, then rst_n = 0 on the 2nd SCAN edge -> IDLE, out_count = 0, in_ready = 1, no out_valid; the next word 0x0004 yields out_count = 2.
